// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with load hazard stall/forward
// Optional word forwarding to hitting loads is enabled by defining STORE_BUFFER_FWD_EN.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_stall,
  output logic        ld_fwd,
  output logic [31:0] ld_fwd_data,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   addr_q  [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          hit;
  logic          fwd_ok;
  logic          load_owns;
  logic          drain;
  logic          accept;
  logic [PW-1:0] idx;
`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] yidx;
`endif

  // Scan from oldest to youngest so the last match recorded is the youngest.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef STORE_BUFFER_FWD_EN
    yidx = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx][31:2] == ld_addr[31:2])) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        yidx = idx;
`endif
      end
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign fwd_ok      = ld_valid && !st_valid && hit && (be_q[yidx] == 4'hF);
  assign ld_fwd      = fwd_ok;
  assign ld_fwd_data = fwd_ok ? wdata_q[yidx] : 32'h0;
`else
  assign fwd_ok      = 1'b0;
  assign ld_fwd      = 1'b0;
  assign ld_fwd_data = 32'h0;
`endif

  assign st_ready  = (count != CW'(DEPTH));
  assign accept    = st_valid && st_ready;
  // A clean load keeps the port even when a conflicting store stalls it.
  assign load_owns = ld_valid && !hit;
  // Reset discards the queue, so nothing may be written in the reset cycle.
  assign drain     = !reset && !load_owns && (count != '0);
  assign ld_stall  = ld_valid && (st_valid || (hit && !fwd_ok));

  assign dm_we    = drain;
  assign dm_addr  = load_owns ? ld_addr : (drain ? addr_q[head] : 32'h0);
  assign dm_wdata = drain ? wdata_q[head] : 32'h0;
  assign dm_be    = drain ? be_q[head] : 4'h0;
  assign dm_pc    = drain ? pc_q[head] : 32'h0;

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail]  <= st_addr;
      wdata_q[tail] <= st_wdata;
      be_q[tail]    <= st_be;
      pc_q[tail]    <= st_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + 1'b1;
      if (drain)  head <= head + 1'b1;
      case ({accept, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        ld_fwd;
  logic [31:0] ld_fwd_data;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [64];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be), .st_pc(st_pc),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall), .ld_fwd(ld_fwd),
    .ld_fwd_data(ld_fwd_data),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_pc(dm_pc)
  );

  always #5 clk = ~clk;

  // Byte-enabled data memory on the DUT's single port.
  always @(posedge clk) begin
    if (dm_we) begin
      for (int b = 0; b < 4; b++)
        if (dm_be[b]) mem[dm_addr[7:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] pc);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_be    = be;
    st_pc    = pc;
  endtask

  task automatic no_store();
    st_valid = 1'b0;
    st_addr  = 32'h0;
    st_wdata = 32'h0;
    st_be    = 4'h0;
    st_pc    = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    no_store();
    ld_valid = 1'b0;
    ld_addr  = 32'h0;
    reset    = 1'b1;
    adv();
    adv();
    reset = 1'b0;

    // Reset state, idle
    settle();
    chk("rst_st_ready", st_ready, 1);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_ld_stall", ld_stall, 0);
    chk("rst_ld_fwd", ld_fwd, 0);
    chk("rst_fwd_data", ld_fwd_data, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_wdata", dm_wdata, 0);
    chk("rst_dm_be", dm_be, 0);
    chk("rst_dm_pc", dm_pc, 0);
    adv();

    // Single store then exactly one drain cycle
    store(32'h10, 32'h1234_5678, 4'hF, 32'h3000);
    settle();
    chk("s1_ready", st_ready, 1);
    chk("s1_no_drain_yet", dm_we, 0);
    adv();
    no_store();
    settle();
    chk("s1_drain_we", dm_we, 1);
    chk("s1_drain_addr", dm_addr, 32'h10);
    chk("s1_drain_wdata", dm_wdata, 32'h1234_5678);
    chk("s1_drain_be", dm_be, 4'hF);
    chk("s1_drain_pc", dm_pc, 32'h3000);
    adv();
    settle();
    chk("s1_after_we", dm_we, 0);
    chk("s1_after_addr", dm_addr, 0);
    chk("s1_mem", mem[4], 32'h1234_5678);
    adv();

    // Fill to DEPTH while an unrelated load holds the port
    ld_valid = 1'b1;
    ld_addr  = 32'h100;
    for (int i = 0; i < DEPTH; i++) begin
      store(32'h40 + 4*i, 32'hA0 + i, 4'hF, 32'h4000 + 4*i);
      settle();
      chk("fill_ready", st_ready, 1);
      chk("fill_we", dm_we, 0);
      chk("fill_conflict_stall", ld_stall, 1);
      chk("fill_dm_addr", dm_addr, 32'h100);
      adv();
    end
    store(32'h50, 32'hDEAD_BEEF, 4'hF, 32'h0);
    settle();
    chk("full_ready", st_ready, 0);
    chk("full_we", dm_we, 0);
    adv();
    no_store();
    settle();
    chk("full_hold_ready", st_ready, 0);
    chk("full_hold_stall", ld_stall, 0);
    chk("full_hold_we", dm_we, 0);
    chk("full_hold_addr", dm_addr, 32'h100);
    adv();
    ld_valid = 1'b0;
    ld_addr  = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      chk("drain_we", dm_we, 1);
      chk("drain_addr", dm_addr, 32'h40 + 4*i);
      chk("drain_wdata", dm_wdata, 32'hA0 + i);
      chk("drain_pc", dm_pc, 32'h4000 + 4*i);
      chk("drain_ready", st_ready, (i == 0) ? 32'd0 : 32'd1);
      adv();
    end
    settle();
    chk("drain_done_we", dm_we, 0);
    chk("rejected_not_written", mem[20], 32'h0);
    chk("last_drained_mem", mem[19], 32'hA3);
    adv();

    // Youngest hit at position 2 behind two unrelated stores
    ld_valid = 1'b1;
    ld_addr  = 32'h100;
    store(32'h30, 32'h1, 4'hF, 32'h5000);
    adv();
    store(32'h34, 32'h2, 4'hF, 32'h5004);
    adv();
    store(32'h20, 32'hAABB_CCDD, 4'hF, 32'h5008);
    adv();
    no_store();
    ld_addr = 32'h22;
`ifdef STORE_BUFFER_FWD_EN
    settle();
    chk("fwd_flag", ld_fwd, 1);
    chk("fwd_data", ld_fwd_data, 32'hAABB_CCDD);
    chk("fwd_stall", ld_stall, 0);
    chk("fwd_drain_we", dm_we, 1);
    chk("fwd_drain_addr", dm_addr, 32'h30);
    adv();
    ld_valid = 1'b0;
    adv();
    adv();
    settle();
    chk("fwd_done_we", dm_we, 0);
    chk("fwd_mem", mem[8], 32'hAABB_CCDD);
    adv();
`else
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("hit_stall", ld_stall, 1);
      chk("hit_fwd", ld_fwd, 0);
      chk("hit_drain_we", dm_we, 1);
      chk("hit_drain_addr", dm_addr, (k == 0) ? 32'h30 : (k == 1) ? 32'h34 : 32'h20);
      adv();
    end
    settle();
    chk("hit_clear_stall", ld_stall, 0);
    chk("hit_clear_we", dm_we, 0);
    chk("hit_clear_addr", dm_addr, 32'h22);
    chk("hit_mem", mem[8], 32'hAABB_CCDD);
    adv();
    ld_valid = 1'b0;
`endif
    ld_addr = 32'h0;

    // Partial-word youngest match always stalls
    store(32'h20, 32'h0000_00EE, 4'h1, 32'h6000);
    settle();
    chk("part_no_drain", dm_we, 0);
    adv();
    no_store();
    ld_valid = 1'b1;
    ld_addr  = 32'h20;
    settle();
    chk("part_stall", ld_stall, 1);
    chk("part_fwd", ld_fwd, 0);
    chk("part_drain_we", dm_we, 1);
    chk("part_drain_be", dm_be, 4'h1);
    adv();
    settle();
    chk("part_clear_stall", ld_stall, 0);
    chk("part_clear_fwd", ld_fwd, 0);
    chk("part_clear_we", dm_we, 0);
    chk("part_clear_addr", dm_addr, 32'h20);
    chk("part_mem", mem[8], 32'hAABB_CCEE);
    adv();

    // Reset discards queued stores without writing them
    ld_addr = 32'h100;
    store(32'h60, 32'h11, 4'hF, 32'h7000);
    adv();
    store(32'h64, 32'h22, 4'hF, 32'h7004);
    adv();
    store(32'h68, 32'h33, 4'hF, 32'h7008);
    adv();
    no_store();
    ld_valid = 1'b0;
    ld_addr  = 32'h0;
    reset    = 1'b1;
    settle();
    chk("rst_cycle_we", dm_we, 0);
    adv();
    reset = 1'b0;
    settle();
    chk("post_rst_ready", st_ready, 1);
    chk("post_rst_we", dm_we, 0);
    chk("post_rst_addr", dm_addr, 0);
    adv();
    settle();
    chk("post_rst_we2", dm_we, 0);
    adv();
    chk("discard_mem0", mem[24], 32'h0);
    chk("discard_mem1", mem[25], 32'h0);
    chk("discard_mem2", mem[26], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the MEM-stage pipeline register and the data memory. Queues stores from the pipeline, so a store retires in one cycle. Drains queued stores to the single-port data memory whenever the port is not needed by a load. Detects load/store address hazards against queued entries and stalls the load, or forwards to it, until the data memory view is consistent.

## Interface
- DEPTH, 4, number of queued stores; power of two, 2..16
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- st_valid  in  1  MEM stage presents a store this cycle
- st_addr  in  32  byte address of store
- st_wdata  in  32  store data, already lane-aligned
- st_be  in  4  byte enables; nonzero when st_valid
- st_pc  in  32  PC of store instruction, carried for the write log
- st_ready  out  1  buffer can accept a store this cycle
- ld_valid  in  1  MEM stage presents a load this cycle
- ld_addr  in  32  byte address of load
- ld_stall  out  1  load must hold in MEM this cycle
- ld_fwd  out  1  load data is taken from ld_fwd_data, not the data memory
- ld_fwd_data  out  32  forwarded word
- dm_we  out  1  data-memory write strobe
- dm_addr  out  32  data-memory address: load address or drain address
- dm_wdata  out  32  drain data
- dm_be  out  4  drain byte enables
- dm_pc  out  32  PC of the draining store

## Operation
- Circular FIFO of DEPTH entries {addr, wdata, be, pc}, with head/tail pointers and a count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Accept: when st_valid && st_ready, write the entry at tail on posedge and increment tail.
- st_ready = (count != DEPTH). A full buffer never accepts, even in a cycle where it drains.
- Hit: ld_valid, and some valid entry has addr[31:2] == ld_addr[31:2]. Only entries already in the FIFO are compared; a store being accepted in the same cycle is not.
- Port arbitration:
  - Load with no hit: the load owns the port, dm_addr = ld_addr, dm_we = 0, ld_stall = 0.
  - Otherwise, if count != 0: drain the head. dm_we = 1, dm_addr/dm_wdata/dm_be/dm_pc come from the head, and head increments on posedge.
  - Load with a hit: ld_stall = 1 and the drain proceeds. The stall clears automatically once no matching entry remains.
  - If count == 0 and there is no load: dm_we = 0 and dm_addr = 0.
- st_valid and ld_valid are mutually exclusive by pipeline construction. If both are asserted, the store is processed and the load is stalled (ld_stall = 1).
- Simultaneous accept and drain: count is unchanged and both pointers advance.
- Reset mid-operation discards all pending entries; there is no drain on reset.
- All outputs are combinational from registered state and inputs. ld_fwd = 0 whenever ld_stall = 1.

## Timing
- Reset values: count = 0 and head = tail = 0, so st_ready = 1, and ld_stall = ld_fwd = dm_we = 0. dm_addr, dm_wdata, dm_be and dm_pc are all 0 (outputs with no load present). ld_fwd_data = 0.
- A store accepted at edge N is eligible to drain in cycle N+1; its memory write lands at edge N+1 at the earliest.
- A load with no hit sees the data memory in the same cycle, so it adds zero latency.
- A load with a hit stalls for k cycles, where k is the position of the youngest matching entry + 1, assuming no new stores arrive.
- Drain throughput is one entry per cycle.

## Configuration
- STORE_BUFFER_FWD_EN
  - Defined: on a hit where the youngest matching entry has be == 4'b1111, ld_stall = 0, ld_fwd = 1, and ld_fwd_data = that entry's wdata. The head still drains in that cycle. A partial-word youngest match stalls as without forwarding.
  - Undefined: ld_fwd is tied to 0, ld_fwd_data to 0, and every hit stalls.

## Test plan
- Reset, then idle → st_ready = 1, dm_we = 0, ld_stall = 0, and all dm_* outputs are 0.
- Store 0x0000_0010 ← 0x1234_5678, be = 4'hF, pc = 0x3000 at edge 1, then idle → exactly one cycle with dm_we = 1, dm_addr = 0x10, dm_wdata = 0x1234_5678, dm_pc = 0x3000, followed by count = 0.
- Issue DEPTH stores while ld_valid is held on an unrelated address 0x100 → st_ready drops after the DEPTH-th store, no drain occurs while the load owns the port, and draining resumes in the cycle ld_valid falls.
- Store 0x20 ← 0xAABB_CCDD, be = 4'hF, with 2 older stores queued to other addresses, then load 0x22:
  - Without the macro: ld_stall stays high for 3 cycles, then clears with the memory holding 0xAABB_CCDD.
  - With STORE_BUFFER_FWD_EN: ld_fwd = 1, ld_fwd_data = 0xAABB_CCDD, and ld_stall = 0.
- Store 0x20 with be = 4'h1 queued, then load 0x20 with the macro defined → ld_stall = 1 until the drain, and ld_fwd stays 0.
- Three stores queued, then reset asserted → the next cycle shows count = 0, dm_we = 0, and no write to the data memory for the discarded entries.
